// File: rtl/noc_vc_credit_rx_buffer.sv
// Generic FWFT FIFO for one VC: head word is visible combinationally while not empty.
// Latency: a word written on edge t is readable from cycle t+1.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
module vc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  // A full FIFO may still take a word when its head leaves on the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage write; contents need no reset since an empty FIFO is never presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Multi-VC credit receive buffer: per-VC FIFOs merged by a packet-locked round-robin arbiter.
// Latency: 1 cycle from input flit to output through an empty buffer; credit 1 cycle after pop.
// Backpressure: none on input (credits only); output holds stable while o_valid && !o_ready.
module noc_vc_credit_rx_buffer #(
  parameter int D_W           = 32,
  parameter int A_W           = 4,
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 32,
  parameter int CNT_W         = $clog2(VC_FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [VC_W-1:0] i_vc,
  input  logic [D_W-1:0]  i_data,
  input  logic            i_last,
  input  logic [A_W-1:0]  i_addr,
  output logic [VC_W-1:0] o_credit,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [D_W-1:0]  o_data,
  output logic            o_last,
  output logic [A_W-1:0]  o_addr,
  output logic [VC_W-1:0] o_vc,
  output logic            o_overflow
);
  localparam int IDX_W  = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam int FLIT_W = D_W + 1 + A_W;

  typedef struct packed {
    logic [D_W-1:0] data;
    logic           last;
    logic [A_W-1:0] addr;
  } flit_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  flit_t            in_flit;
  flit_t            fifo_dout [VC_W];
  flit_t            head;
  logic [VC_W-1:0]  fifo_empty;
  logic [VC_W-1:0]  fifo_full;
  logic [VC_W-1:0]  fifo_push;
  logic [VC_W-1:0]  fifo_pop;
  logic [VC_W-1:0]  nonempty;
  logic [VC_W-1:0]  grant_oh;
  logic             vc_ok;
  logic             accept_any;
  logic             push_drop;
  logic             out_vld;
  logic             pop;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] lock_vc_q, lock_vc_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             rr_found;
  logic [IDX_W-1:0] grant;

  logic [VC_W-1:0]  credit_q;
  logic             overflow_q;

  assign in_flit = '{data: i_data, last: i_last, addr: i_addr};

  // Exactly one VC bit must be set for a flit to be storable.
  assign vc_ok      = (i_vc != '0) && ((i_vc & (i_vc - VC_W'(1))) == '0);
  assign fifo_push  = (i_valid && vc_ok) ? i_vc : '0;
  assign accept_any = |(i_vc & (~fifo_full | fifo_pop));
  assign push_drop  = i_valid && (!vc_ok || !accept_any);
  assign nonempty   = ~fifo_empty;

  for (genvar v = 0; v < VC_W; v++) begin : gen_vc
    vc_fifo #(
      .W     (FLIT_W),
      .DEPTH (VC_FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push[v]),
      .pop   (fifo_pop[v]),
      .din   (in_flit),
      .dout  (fifo_dout[v]),
      .empty (fifo_empty[v]),
      .full  (fifo_full[v])
    );
  end

  // Round-robin search: first non-empty VC at or above the pointer, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = rr_ptr_q;
    cand     = '0;
    for (int i = 0; i < VC_W; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % VC_W);
      if (!rr_found && nonempty[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Grant and output view; a locked VC keeps the grant even when it runs dry mid-packet.
  always_comb begin
    grant    = (state_q == ARB_LOCKED) ? lock_vc_q : rr_idx;
    out_vld  = (state_q == ARB_LOCKED) ? nonempty[lock_vc_q] : (|nonempty);
    grant_oh = VC_W'(1) << grant;
    head     = fifo_dout[grant];
    pop      = out_vld && o_ready;
    fifo_pop = pop ? grant_oh : '0;
  end

  // Arbiter next state: a last-flit pop releases the lock and rotates the pointer.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    if (pop && head.last) begin
      state_d  = ARB_IDLE;
      rr_ptr_d = (grant == IDX_W'(VC_W - 1)) ? '0 : grant + IDX_W'(1);
    end else if (state_q == ARB_IDLE && out_vld) begin
      state_d   = ARB_LOCKED;
      lock_vc_d = grant;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // One credit pulse per freed entry, one cycle after the pop; overflow is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= fifo_pop;
      overflow_q <= overflow_q | push_drop;
    end
  end

  assign o_credit   = credit_q;
  assign o_overflow = overflow_q;
  assign o_valid    = out_vld;
  assign o_data     = out_vld ? head.data : '0;
  assign o_last     = out_vld ? head.last : 1'b0;
  assign o_addr     = out_vld ? head.addr : '0;
  assign o_vc       = out_vld ? grant_oh : '0;
endmodule

// File: tb/tb_noc_vc_credit_rx_buffer.sv
module tb_noc_vc_credit_rx_buffer;
  localparam int D_W   = 32;
  localparam int A_W   = 4;
  localparam int VC_W  = 2;
  localparam int DEPTH = 4;
  localparam int NVEC  = 21;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            i_valid;
  logic [VC_W-1:0] i_vc;
  logic [D_W-1:0]  i_data;
  logic            i_last;
  logic [A_W-1:0]  i_addr;
  logic [VC_W-1:0] o_credit;
  logic            o_valid;
  logic            o_ready;
  logic [D_W-1:0]  o_data;
  logic            o_last;
  logic [A_W-1:0]  o_addr;
  logic [VC_W-1:0] o_vc;
  logic            o_overflow;

  noc_vc_credit_rx_buffer #(
    .D_W           (D_W),
    .A_W           (A_W),
    .VC_W          (VC_W),
    .VC_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_vc       (i_vc),
    .i_data     (i_data),
    .i_last     (i_last),
    .i_addr     (i_addr),
    .o_credit   (o_credit),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_addr     (o_addr),
    .o_vc       (o_vc),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VC_W-1:0] vc;
    logic [D_W-1:0]  data;
    logic            last;
    logic [A_W-1:0]  addr;
  } flit_t;

  typedef struct {
    bit              rst;
    bit              vld;
    logic [VC_W-1:0] vc;
    logic [D_W-1:0]  data;
    bit              last;
    logic [A_W-1:0]  addr;
    bit              rdy;
    bit              exp_valid;
    bit              exp_ovf;
  } vec_t;

  flit_t           sb[$];
  flit_t           mon_e;
  logic [VC_W-1:0] pend_credit = '0;
  vec_t            vecs[NVEC];
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit rst, bit vld, logic [VC_W-1:0] vc, logic [D_W-1:0] d,
                               bit last, logic [A_W-1:0] a, bit rdy, bit ev, bit eo);
    vec_t r;
    r.rst = rst; r.vld = vld; r.vc = vc; r.data = d; r.last = last; r.addr = a;
    r.rdy = rdy; r.exp_valid = ev; r.exp_ovf = eo;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_valid = 1'b0; i_vc = '0; i_data = '0; i_last = 1'b0; i_addr = '0;
  endtask

  task automatic push_flit(input logic [VC_W-1:0] vc, input logic [D_W-1:0] d,
                           input logic last, input logic [A_W-1:0] a, input bit to_sb);
    flit_t f;
    i_valid = 1'b1; i_vc = vc; i_data = d; i_last = last; i_addr = a;
    if (to_sb) begin
      f.vc = vc; f.data = d; f.last = last; f.addr = a;
      sb.push_back(f);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    o_ready = 1'b0;
    idle_in();
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for all expected beats, then confirm the output goes idle.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " beats left"}, sb.size(), 0);
    @(negedge clk);
    chk({name, " idle after drain"}, o_valid, 1'b0);
  endtask

  // Scoreboard monitor: compare each handshaked beat and the credit pulse that follows it.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_credit = '0;
    end else begin
      chk("o_credit", o_credit, pend_credit);
      pend_credit = '0;
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h vc %0h with nothing expected", o_data, o_vc);
        end else begin
          mon_e = sb.pop_front();
          chk("beat o_data", o_data, mon_e.data);
          chk("beat o_vc", o_vc, mon_e.vc);
          chk("beat o_last", o_last, mon_e.last);
          chk("beat o_addr", o_addr, mon_e.addr);
          pend_credit = mon_e.vc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single 3-flit packet on VC0, always ready.
    vecs[0]  = mkv(0, 1, 2'b01, 32'h1111_0001, 0, 4'h1, 1, 0, 0);
    vecs[1]  = mkv(0, 1, 2'b01, 32'h1111_0002, 0, 4'h2, 1, 1, 0);
    vecs[2]  = mkv(0, 1, 2'b01, 32'h1111_0003, 1, 4'h3, 1, 1, 0);
    vecs[3]  = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[4]  = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 0, 0);
    // Packet A (VC0, fills it), packet B (VC1), D on VC1, C on VC0 pushed into a full VC0 with a pop.
    vecs[5]  = mkv(1, 1, 2'b01, 32'hA000_0000, 0, 4'h4, 0, 0, 0);
    vecs[6]  = mkv(0, 1, 2'b01, 32'hA000_0001, 0, 4'h4, 0, 1, 0);
    vecs[7]  = mkv(0, 1, 2'b01, 32'hA000_0002, 0, 4'h4, 0, 1, 0);
    vecs[8]  = mkv(0, 1, 2'b01, 32'hA000_0003, 1, 4'h4, 0, 1, 0);
    vecs[9]  = mkv(0, 1, 2'b10, 32'hB000_0000, 0, 4'h8, 0, 1, 0);
    vecs[10] = mkv(0, 1, 2'b10, 32'hB000_0001, 1, 4'h8, 0, 1, 0);
    vecs[11] = mkv(0, 1, 2'b01, 32'hC000_0000, 1, 4'hC, 1, 1, 0);
    vecs[12] = mkv(0, 1, 2'b10, 32'hD000_0000, 1, 4'hD, 1, 1, 0);
    vecs[13] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[14] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[15] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[16] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[17] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[18] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 1, 0);
    vecs[19] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 0, 0);
    vecs[20] = mkv(0, 0, 2'b00, 32'h0,         0, 4'h0, 1, 0, 0);

    idle_in();
    o_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset o_valid", o_valid, 1'b0);
    chk("reset o_credit", o_credit, 2'b00);
    chk("reset o_overflow", o_overflow, 1'b0);
    chk("reset o_data", o_data, 32'h0);
    chk("reset o_vc", o_vc, 2'b00);
    chk("reset o_last", o_last, 1'b0);
    chk("reset o_addr", o_addr, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      tick();
      if (vecs[k].rst) begin
        do_reset();
        tick();
      end
      o_ready = vecs[k].rdy;
      if (vecs[k].vld) push_flit(vecs[k].vc, vecs[k].data, vecs[k].last, vecs[k].addr, 1'b1);
      else idle_in();
      @(negedge clk);
      chk($sformatf("vec%0d o_valid", k), o_valid, vecs[k].exp_valid);
      chk($sformatf("vec%0d o_overflow", k), o_overflow, vecs[k].exp_ovf);
    end
    chk("table beats left", sb.size(), 0);

    // Stalled head stays put while VC1 fills behind it.
    tick();
    o_ready = 1'b0;
    push_flit(2'b01, 32'hDEAD_BEEF, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 3) push_flit(2'b10, 32'hB100_0000 + i, (i == 2), 4'h6, 1'b1);
      else idle_in();
      @(negedge clk);
      chk($sformatf("hold%0d o_valid", i), o_valid, 1'b1);
      chk($sformatf("hold%0d o_data", i), o_data, 32'hDEAD_BEEF);
      chk($sformatf("hold%0d o_vc", i), o_vc, 2'b01);
      chk($sformatf("hold%0d o_addr", i), o_addr, 4'h5);
    end
    tick();
    o_ready = 1'b1;
    idle_in();
    drain("hold", 20);

    // Full VC1: push coinciding with a pop is legal; a 5th push with no pop overflows.
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      o_ready = 1'b0;
      push_flit(2'b10, 32'hF000_0000 + i, 1'b1, 4'(i), 1'b1);
    end
    tick();
    o_ready = 1'b1;
    push_flit(2'b10, 32'hF000_0004, 1'b1, 4'h4, 1'b1);
    tick();
    o_ready = 1'b0;
    idle_in();
    @(negedge clk);
    chk("full push+pop no overflow", o_overflow, 1'b0);
    tick();
    push_flit(2'b10, 32'hF000_0005, 1'b1, 4'h5, 1'b0);
    tick();
    idle_in();
    @(negedge clk);
    chk("full push overflow", o_overflow, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("overflow sticky", o_overflow, 1'b1);
    tick();
    o_ready = 1'b1;
    drain("full", 20);
    chk("overflow sticky after drain", o_overflow, 1'b1);

    // Multi-hot VC is dropped and flagged; stored contents unchanged.
    tick();
    do_reset();
    tick();
    chk("post reset overflow clear", o_overflow, 1'b0);
    push_flit(2'b01, 32'h6000_0000, 1'b1, 4'h7, 1'b1);
    tick();
    push_flit(2'b11, 32'hBAD0_BAD0, 1'b1, 4'h8, 1'b0);
    tick();
    idle_in();
    @(negedge clk);
    chk("multihot overflow", o_overflow, 1'b1);
    tick();
    o_ready = 1'b1;
    drain("multihot", 20);

    // Reset mid-packet with 3 entries stored and a credit in flight.
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      o_ready = 1'b0;
      push_flit(2'b01, 32'h7000_0000 + i, 1'b0, 4'(i), 1'b1);
    end
    tick();
    o_ready = 1'b1;
    idle_in();
    tick();
    o_ready = 1'b0;
    chk("pre-reset o_credit", o_credit, 2'b01);
    chk("pre-reset o_valid", o_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset o_valid", o_valid, 1'b0);
    chk("mid-reset o_credit", o_credit, 2'b00);
    do_reset();
    tick();
    o_ready = 1'b1;
    push_flit(2'b01, 32'h600D_F00D, 1'b1, 4'h9, 1'b1);
    @(negedge clk);
    chk("post-reset empty before edge", o_valid, 1'b0);
    tick();
    idle_in();
    @(negedge clk);
    chk("post-reset 1-cycle o_valid", o_valid, 1'b1);
    chk("post-reset 1-cycle o_data", o_data, 32'h600D_F00D);
    tick();
    drain("post-reset", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
